pipe_link_channel: RTL and testbench

- Behavioural PIPE channel joining the PIPE ports of two PCIE_TOP instances: side A (RC) and side B (EP).
- Carries each side's tx beats to the other side's rx port through a fixed-latency delay line.
- Models link-down beat loss.
- Injects a single-bit error into a chosen beat so the DLL LCRC check, NAK and retry-buffer replay paths can be exercised at system level.

---
 rtl/pipe_link_channel.sv | 155 +++++++++++++++
 tb/tb_pipe_link_channel.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_link_channel.sv
// Behavioural PIPE channel between two link partners, with link-down beat loss and single-bit error injection.
// Latency LATENCY cycles per direction; no backpressure, and beats offered while the link is down are dropped.
module pipe_link_channel #(
  parameter int PIPE_DATA_WIDTH = 256,
  parameter int LATENCY         = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PIPE_DATA_WIDTH-1:0]         a_txdata_i,
  input  logic                               a_txvalid_i,
  output logic [PIPE_DATA_WIDTH-1:0]         a_rxdata_o,
  output logic                               a_rxvalid_o,
  input  logic [PIPE_DATA_WIDTH-1:0]         b_txdata_i,
  input  logic                               b_txvalid_i,
  output logic [PIPE_DATA_WIDTH-1:0]         b_rxdata_o,
  output logic                               b_rxvalid_o,
  input  logic                               link_up_i,
  input  logic                               inj_arm_i,
  input  logic                               inj_dir_i,
  input  logic [15:0]                        inj_beat_i,
  input  logic [$clog2(PIPE_DATA_WIDTH)-1:0] inj_bit_i,
  output logic                               inj_busy_o,
  output logic                               inj_done_o,
  output logic [CNT_WIDTH-1:0]               ab_beat_cnt_o,
  output logic [CNT_WIDTH-1:0]               ba_beat_cnt_o,
  output logic [CNT_WIDTH-1:0]               drop_cnt_o
);

  localparam int BIT_W = $clog2(PIPE_DATA_WIDTH);

  typedef struct packed {
    logic                       vld;
    logic [PIPE_DATA_WIDTH-1:0] dat;
  } beat_t;

  typedef enum logic {IDLE, ARMED} state_t;

  beat_t ab_q [LATENCY];
  beat_t ba_q [LATENCY];

  state_t               state_q, state_d;
  logic                 dir_q, dir_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [15:0]          skip_q, skip_d;
  logic                 done_d;
  logic                 hit;
  logic [PIPE_DATA_WIDTH-1:0] flip_mask, ab_flip, ba_flip;

  logic ab_acc, ba_acc, ab_drop, ba_drop;
  logic [1:0] drop_inc;

  assign ab_acc   = a_txvalid_i & link_up_i;
  assign ba_acc   = b_txvalid_i & link_up_i;
  assign ab_drop  = a_txvalid_i & ~link_up_i;
  assign ba_drop  = b_txvalid_i & ~link_up_i;
  assign drop_inc = {1'b0, ab_drop} + {1'b0, ba_drop};

  assign flip_mask = {{(PIPE_DATA_WIDTH-1){1'b0}}, 1'b1} << bit_q;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [1:0] n);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, n};
    return s[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
  endfunction

  // Injection FSM: the beat in the arm cycle is never eligible because state is still IDLE.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    bit_d   = bit_q;
    skip_d  = skip_q;
    done_d  = 1'b0;
    ab_flip = '0;
    ba_flip = '0;
    hit     = dir_q ? ba_acc : ab_acc;
    case (state_q)
      IDLE: begin
        if (inj_arm_i) begin
          state_d = ARMED;
          dir_d   = inj_dir_i;
          bit_d   = inj_bit_i;
          skip_d  = inj_beat_i;
        end
      end
      ARMED: begin
        if (hit) begin
          if (skip_q != 16'd0) begin
            skip_d = skip_q - 16'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (dir_q) ba_flip = flip_mask;
            else       ab_flip = flip_mask;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      bit_q      <= '0;
      skip_q     <= '0;
      inj_done_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      bit_q      <= bit_d;
      skip_q     <= skip_d;
      inj_done_o <= done_d;
    end
  end

  assign inj_busy_o = (state_q == ARMED);

  // Delay lines shift unconditionally; idle slots carry zero data so rx data is 0 when not valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        ab_q[i] <= '0;
        ba_q[i] <= '0;
      end
    end else begin
      ab_q[0] <= beat_t'{vld: ab_acc, dat: ab_acc ? (a_txdata_i ^ ab_flip) : '0};
      ba_q[0] <= beat_t'{vld: ba_acc, dat: ba_acc ? (b_txdata_i ^ ba_flip) : '0};
      for (int i = 1; i < LATENCY; i++) begin
        ab_q[i] <= ab_q[i-1];
        ba_q[i] <= ba_q[i-1];
      end
    end
  end

  assign b_rxvalid_o = ab_q[LATENCY-1].vld;
  assign b_rxdata_o  = ab_q[LATENCY-1].dat;
  assign a_rxvalid_o = ba_q[LATENCY-1].vld;
  assign a_rxdata_o  = ba_q[LATENCY-1].dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_beat_cnt_o <= '0;
      ba_beat_cnt_o <= '0;
      drop_cnt_o    <= '0;
    end else begin
      ab_beat_cnt_o <= sat_add(ab_beat_cnt_o, {1'b0, ab_acc});
      ba_beat_cnt_o <= sat_add(ba_beat_cnt_o, {1'b0, ba_acc});
      drop_cnt_o    <= sat_add(drop_cnt_o, drop_inc);
    end
  end

endmodule

// File: tb/tb_pipe_link_channel.sv
// Directed bench for pipe_link_channel: latency, streaming, link-down drops, error injection, reset.
module tb_pipe_link_channel;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] a_txdata = '0, b_txdata = '0;
  logic         a_txvalid = 1'b0, b_txvalid = 1'b0;
  logic [255:0] a_rxdata, b_rxdata;
  logic         a_rxvalid, b_rxvalid;
  logic         link_up = 1'b1;
  logic         inj_arm = 1'b0, inj_dir = 1'b0;
  logic [15:0]  inj_beat = '0;
  logic [7:0]   inj_bit = '0;
  logic         inj_busy, inj_done;
  logic [31:0]  ab_cnt, ba_cnt, drop_cnt;

  int checks = 0;
  int errors = 0;

  pipe_link_channel #(.PIPE_DATA_WIDTH(256), .LATENCY(4), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_txdata_i(a_txdata), .a_txvalid_i(a_txvalid), .a_rxdata_o(a_rxdata), .a_rxvalid_o(a_rxvalid),
    .b_txdata_i(b_txdata), .b_txvalid_i(b_txvalid), .b_rxdata_o(b_rxdata), .b_rxvalid_o(b_rxvalid),
    .link_up_i(link_up), .inj_arm_i(inj_arm), .inj_dir_i(inj_dir), .inj_beat_i(inj_beat),
    .inj_bit_i(inj_bit), .inj_busy_o(inj_busy), .inj_done_o(inj_done),
    .ab_beat_cnt_o(ab_cnt), .ba_beat_cnt_o(ba_cnt), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] pa(input int i);
    return {8{32'(32'hA5A50000 + i)}};
  endfunction

  function automatic logic [255:0] pb(input int i);
    return {8{32'(32'h5B5B0000 + i)}};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    a_txvalid = 1'b0; a_txdata = '0;
    b_txvalid = 1'b0; b_txdata = '0;
    inj_arm = 1'b0; link_up = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_rxvalid, b_rxvalid, inj_busy, inj_done} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {a_rxvalid, b_rxvalid, inj_busy, inj_done});
    end
    checks++;
    if (a_rxdata !== '0 || b_rxdata !== '0) begin
      errors++; $display("FAIL reset_data got a=%h b=%h exp 0", a_rxdata, b_rxdata);
    end
    checks++;
    if (ab_cnt !== 0 || ba_cnt !== 0 || drop_cnt !== 0) begin
      errors++; $display("FAIL reset_cnt got ab=%0d ba=%0d drop=%0d exp 0", ab_cnt, ba_cnt, drop_cnt);
    end
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [255:0] pat;
    logic exp_v;
    pat = {32'hDEADBEEF, {6{32'h12345678}}, 32'hC0FFEE01};
    do_reset();
    cyc();
    a_txvalid = 1'b1; a_txdata = pat;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      if (c == 1) clear_inputs();
      exp_v = (c == 4);
      checks++;
      if (b_rxvalid !== exp_v || b_rxdata !== (exp_v ? pat : 256'd0)) begin
        errors++; $display("FAIL single_b c=%0d got v=%b d=%h exp v=%b", c, b_rxvalid, b_rxdata, exp_v);
      end
      checks++;
      if (a_rxvalid !== 1'b0) begin
        errors++; $display("FAIL single_a_quiet c=%0d got %b exp 0", c, a_rxvalid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    do_reset();
    cyc();
    a_txvalid = 1'b1; a_txdata = pa(0);
    b_txvalid = 1'b1; b_txdata = pb(0);
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (c < 8) begin
        a_txdata = pa(c); b_txdata = pb(c);
      end else begin
        clear_inputs();
      end
      exp_v = (c >= 4 && c <= 11);
      checks++;
      if (b_rxvalid !== exp_v || b_rxdata !== (exp_v ? pa(c-4) : 256'd0)) begin
        errors++; $display("FAIL b2b_b c=%0d got v=%b d=%h exp v=%b", c, b_rxvalid, b_rxdata, exp_v);
      end
      checks++;
      if (a_rxvalid !== exp_v || a_rxdata !== (exp_v ? pb(c-4) : 256'd0)) begin
        errors++; $display("FAIL b2b_a c=%0d got v=%b d=%h exp v=%b", c, a_rxvalid, a_rxdata, exp_v);
      end
    end
    checks++;
    if (ab_cnt !== 8 || ba_cnt !== 8 || drop_cnt !== 0) begin
      errors++; $display("FAIL b2b_cnt got ab=%0d ba=%0d drop=%0d exp 8 8 0", ab_cnt, ba_cnt, drop_cnt);
    end
  endtask

  task automatic test_link_drop();
    logic exp_v;
    do_reset();
    cyc();
    a_txvalid = 1'b1; a_txdata = pa(0);
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (c <= 9) begin
        a_txdata = pa(c);
        link_up  = !(c >= 3 && c <= 5);
      end else begin
        clear_inputs();
      end
      exp_v = (c >= 4 && c <= 13) && !(c >= 7 && c <= 9);
      checks++;
      if (b_rxvalid !== exp_v || b_rxdata !== (exp_v ? pa(c-4) : 256'd0)) begin
        errors++; $display("FAIL drop_b c=%0d got v=%b d=%h exp v=%b", c, b_rxvalid, b_rxdata, exp_v);
      end
    end
    checks++;
    if (ab_cnt !== 7 || drop_cnt !== 3) begin
      errors++; $display("FAIL drop_cnt got ab=%0d drop=%0d exp 7 3", ab_cnt, drop_cnt);
    end
    link_up = 1'b0; a_txvalid = 1'b1; b_txvalid = 1'b1;
    cyc();
    clear_inputs();
    checks++;
    if (drop_cnt !== 5 || ba_cnt !== 0 || ab_cnt !== 7) begin
      errors++; $display("FAIL drop_both got drop=%0d ba=%0d ab=%0d exp 5 0 7", drop_cnt, ba_cnt, ab_cnt);
    end
  endtask

  task automatic test_inject();
    logic [255:0] m, exp_d;
    logic exp_v;
    m = '0; m[5] = 1'b1;
    do_reset();
    cyc();
    inj_arm = 1'b1; inj_dir = 1'b0; inj_beat = 16'd2; inj_bit = 8'd5;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      inj_arm = 1'b0;
      if (c <= 4) begin
        a_txvalid = 1'b1; a_txdata = pa(c-1);
        b_txvalid = 1'b1; b_txdata = pb(c-1);
      end else begin
        clear_inputs();
      end
      checks++;
      if (inj_busy !== (c <= 3) || inj_done !== (c == 4)) begin
        errors++; $display("FAIL inj_flags c=%0d got busy=%b done=%b", c, inj_busy, inj_done);
      end
      exp_v = (c >= 5 && c <= 8);
      exp_d = exp_v ? (pa(c-5) ^ ((c == 7) ? m : 256'd0)) : 256'd0;
      checks++;
      if (b_rxvalid !== exp_v || b_rxdata !== exp_d) begin
        errors++; $display("FAIL inj_b c=%0d got v=%b d=%h exp v=%b d=%h", c, b_rxvalid, b_rxdata, exp_v, exp_d);
      end
      checks++;
      if (a_rxvalid !== exp_v || a_rxdata !== (exp_v ? pb(c-5) : 256'd0)) begin
        errors++; $display("FAIL inj_a_clean c=%0d got v=%b d=%h", c, a_rxvalid, a_rxdata);
      end
    end
  endtask

  task automatic test_arm_same_cycle();
    logic [255:0] m0, m3, exp_d;
    logic exp_v;
    m0 = '0; m0[0] = 1'b1;
    m3 = '0; m3[3] = 1'b1;
    do_reset();
    cyc();
    inj_arm = 1'b1; inj_dir = 1'b0; inj_beat = 16'd0; inj_bit = 8'd0;
    a_txvalid = 1'b1; a_txdata = pa(0);
    for (int c = 1; c <= 9; c++) begin
      cyc();
      case (c)
        1: begin inj_arm = 1'b1; inj_bit = 8'd7; a_txdata = pa(1); end
        2: begin inj_arm = 1'b1; inj_dir = 1'b1; inj_bit = 8'd3; a_txdata = pa(2); end
        3: begin inj_arm = 1'b0; a_txvalid = 1'b0; a_txdata = '0; b_txvalid = 1'b1; b_txdata = pb(0); end
        default: clear_inputs();
      endcase
      checks++;
      if (inj_busy !== (c == 1 || c == 3) || inj_done !== (c == 2 || c == 4)) begin
        errors++; $display("FAIL same_flags c=%0d got busy=%b done=%b", c, inj_busy, inj_done);
      end
      exp_v = (c >= 4 && c <= 6);
      exp_d = exp_v ? (pa(c-4) ^ ((c == 5) ? m0 : 256'd0)) : 256'd0;
      checks++;
      if (b_rxvalid !== exp_v || b_rxdata !== exp_d) begin
        errors++; $display("FAIL same_b c=%0d got v=%b d=%h exp v=%b d=%h", c, b_rxvalid, b_rxdata, exp_v, exp_d);
      end
      exp_v = (c == 7);
      exp_d = exp_v ? (pb(0) ^ m3) : 256'd0;
      checks++;
      if (a_rxvalid !== exp_v || a_rxdata !== exp_d) begin
        errors++; $display("FAIL same_a c=%0d got v=%b d=%h exp v=%b d=%h", c, a_rxvalid, a_rxdata, exp_v, exp_d);
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    cyc();
    inj_arm = 1'b1; inj_dir = 1'b0; inj_beat = 16'd5; inj_bit = 8'd1;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      inj_arm = 1'b0;
      a_txvalid = 1'b1; a_txdata = pa(c);
    end
    cyc();
    clear_inputs();
    checks++;
    if (ab_cnt !== 3 || inj_busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre got ab=%0d busy=%b exp 3 1", ab_cnt, inj_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (inj_busy !== 1'b0 || ab_cnt !== 0 || b_rxvalid !== 1'b0 || b_rxdata !== '0) begin
      errors++; $display("FAIL mid_rst got busy=%b ab=%0d bv=%b", inj_busy, ab_cnt, b_rxvalid);
    end
    cyc();
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      checks++;
      if (b_rxvalid !== 1'b0 || a_rxvalid !== 1'b0 || inj_done !== 1'b0 || inj_busy !== 1'b0) begin
        errors++; $display("FAIL mid_post c=%0d got bv=%b av=%b done=%b busy=%b", c, b_rxvalid, a_rxvalid, inj_done, inj_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_link_drop();
    test_inject();
    test_arm_same_cycle();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
